// File: rtl/mips_cpu_muldiv_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit.
package mips_cpu_muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'b000,
        OP_MULTU = 3'b001,
        OP_DIV   = 3'b010,
        OP_DIVU  = 3'b011,
        OP_MTHI  = 3'b100,
        OP_MTLO  = 3'b101
    } op_e;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } state_e;

    // Codes 000..011 are the iterative ops; bit1 picks divide, bit0 picks unsigned.
    function automatic logic op_is_muldiv(input logic [2:0] op);
        return ~op[2];
    endfunction

endpackage

// File: rtl/mips_cpu_muldiv_step.sv
// One iteration of shift-add multiply or restoring divide on a 2*WIDTH accumulator.
// Multiply: acc = {partial product high, multiplier still to consume}.
// Divide:   acc = {remainder, dividend bits still to consume / quotient bits}.
module mips_cpu_muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic                 is_div,
    input  logic [WIDTH-1:0]     b,
    input  logic [2*WIDTH-1:0]   acc,
    output logic [2*WIDTH-1:0]   acc_next
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // Conditional add then shift right, or trial subtract with restore then shift left.
    always_comb begin
        sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, b} : '0);
        shifted = acc[2*WIDTH-1:WIDTH-1];
        diff    = shifted - {1'b0, b};
        if (!is_div)
            acc_next = {sum, acc[WIDTH-1:1]};
        else if (!diff[WIDTH])
            acc_next = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        else
            acc_next = {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end

endmodule

// File: rtl/mips_cpu_muldiv.sv
// Multi-cycle MULT/MULTU/DIV/DIVU/MTHI/MTLO unit owning HI/LO.
// Operands are reduced to magnitudes on entry; signs are reapplied in FIX.
module mips_cpu_muldiv
    import mips_cpu_muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q;
    logic [2*WIDTH-1:0]   acc_q, acc_next;
    logic [WIDTH-1:0]     b_q, dvd_q, hi_q, lo_q;
    logic                 div_q, neg_hi_q, neg_lo_q, dz_q, done_q;

    logic                 accept, sgn, a_neg, b_neg;
    logic [WIDTH-1:0]     a_mag, b_mag, fix_hi, fix_lo;

    mips_cpu_muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div   (div_q),
        .b        (b_q),
        .acc      (acc_q),
        .acc_next (acc_next)
    );

    // Operand conditioning: signed ops work on magnitudes.
    always_comb begin
        accept = (state_q == IDLE) && start && op_is_muldiv(op);
        sgn    = ~op[0];
        a_neg  = sgn & op1[WIDTH-1];
        b_neg  = sgn & op2[WIDTH-1];
        a_mag  = a_neg ? -op1 : op1;
        b_mag  = b_neg ? -op2 : op2;
    end

    // Final sign correction; divide-by-zero overrides the iterative result.
    always_comb begin
        fix_hi = acc_q[2*WIDTH-1:WIDTH];
        fix_lo = acc_q[WIDTH-1:0];
        if (!div_q) begin
            {fix_hi, fix_lo} = neg_lo_q ? -acc_q : acc_q;
        end else if (dz_q) begin
            fix_hi = dvd_q;
            fix_lo = '1;
        end else begin
            if (neg_lo_q) fix_lo = -acc_q[WIDTH-1:0];
            if (neg_hi_q) fix_hi = -acc_q[2*WIDTH-1:WIDTH];
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = RUN;
            RUN:     if (cnt_q == LAST) state_d = FIX;
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath: operand latch, iteration, HI/LO write-back and done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            acc_q    <= '0;
            b_q      <= '0;
            dvd_q    <= '0;
            div_q    <= 1'b0;
            neg_hi_q <= 1'b0;
            neg_lo_q <= 1'b0;
            dz_q     <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= (state_q == FIX);
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        cnt_q    <= '0;
                        div_q    <= op[1];
                        dvd_q    <= op1;
                        dz_q     <= (op2 == '0);
                        neg_lo_q <= a_neg ^ b_neg;
                        neg_hi_q <= op[1] ? a_neg : (a_neg ^ b_neg);
                        // Multiply consumes the multiplier from the low half;
                        // divide consumes the dividend from the low half.
                        acc_q    <= {{WIDTH{1'b0}}, op[1] ? a_mag : b_mag};
                        b_q      <= op[1] ? b_mag : a_mag;
                    end else if (start && op == OP_MTHI) begin
                        hi_q <= op1;
                    end else if (start && op == OP_MTLO) begin
                        lo_q <= op1;
                    end
                end
                RUN: begin
                    acc_q <= acc_next;
                    cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
                end
                FIX: begin
                    hi_q <= fix_hi;
                    lo_q <= fix_lo;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mips_cpu_muldiv.sv
// Directed bench for the HI/LO multiply/divide unit (WIDTH=32).
module tb_mips_cpu_muldiv;
    import mips_cpu_muldiv_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [2:0]   op = 3'b000;
    logic [W-1:0] op1 = '0, op2 = '0;
    logic         busy, done;
    logic [W-1:0] hi, lo;

    int checks = 0;
    int failures = 0;

    mips_cpu_muldiv #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .op1   (op1),
        .op2   (op2),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h", tag, act, exp);
        end
    endtask

    // Issue one mul/div in cycle 0 and follow it to the done cycle (WIDTH+2),
    // checking the busy/done profile, HI/LO hold, and the final result.
    task automatic run_op(input string tag, input logic [2:0] o,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo,
                          input bit inj);
        logic [W-1:0] old_hi, old_lo;
        bit bad_prof, bad_hold;
        bad_prof = 0;
        bad_hold = 0;
        @(negedge clk);
        old_hi = hi;
        old_lo = lo;
        start = 1'b1; op = o; op1 = a; op2 = b;
        for (int c = 1; c <= W + 2; c++) begin
            @(negedge clk);
            if (busy !== (c <= W + 1)) bad_prof = 1;
            if (done !== (c == W + 2)) bad_prof = 1;
            if (c <= W + 1 && (hi !== old_hi || lo !== old_lo)) bad_hold = 1;
            start = 1'b0;
            op1 = $urandom;
            op2 = $urandom;
            if (inj && c == 5)  begin start = 1'b1; op = OP_MTLO; op1 = 32'h55; end
            if (inj && c == 10) begin start = 1'b1; op = OP_DIV;  op1 = 32'd9; op2 = 32'd3; end
        end
        chk({tag, "_profile"}, 64'(bad_prof), 64'd0);
        chk({tag, "_hold"},    64'(bad_hold), 64'd0);
        chk({tag, "_hi"}, 64'(hi), 64'(exp_hi));
        chk({tag, "_lo"}, 64'(lo), 64'(exp_lo));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [W-1:0] old_lo;

        // Reset state while held in reset.
        #12;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_hi",   64'(hi),   64'd0);
        chk("rst_lo",   64'(lo),   64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("multu_max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 0);
        run_op("mult_neg",  OP_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 0);
        run_op("div_neg",   OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 0);
        run_op("div_negb",  OP_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 0);
        run_op("divu",      OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       0);
        run_op("divu_z",    OP_DIVU,  32'd7,        32'd0,        32'd7,        32'hFFFFFFFF, 0);
        run_op("div_z",     OP_DIV,   32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF, 0);
        run_op("div_ovf",   OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 0);

        // MTHI while idle: immediate write, no busy, no done.
        @(negedge clk);
        old_lo = lo;
        start = 1'b1; op = OP_MTHI; op1 = 32'h1234;
        @(negedge clk);
        start = 1'b0;
        chk("mthi_hi",   64'(hi),   64'h1234);
        chk("mthi_lo",   64'(lo),   64'(old_lo));
        chk("mthi_busy", 64'(busy), 64'd0);
        chk("mthi_done", 64'(done), 64'd0);

        // Starts while busy (MTLO, DIV) must be ignored.
        run_op("multu_inj", OP_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1);
        @(negedge clk);
        chk("inj_idle", 64'(busy), 64'd0);

        // Asynchronous reset mid-DIVU.
        @(negedge clk);
        start = 1'b1; op = OP_DIVU; op1 = 32'd100; op2 = 32'd7;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        chk("arst_pre_busy", 64'(busy), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_done", 64'(done), 64'd0);
        chk("arst_hi",   64'(hi),   64'd0);
        chk("arst_lo",   64'(lo),   64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("multu_post", OP_MULTU, 32'd3, 32'd5, 32'd0, 32'd15, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
